// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and sizing helpers for binary_to_bcd_converter
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed for 2^width - 1; 2^width is never a power of ten,
  // so this equals ceil(log10(2^width)).
  function automatic int bcd_digits(input int width);
    longint unsigned v;
    int n;
    v = 64'd1 << width;
    v = v - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  function automatic int clog2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << n) < value) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// rtl/bcd_add3_cell.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_add3_cell (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// rtl/binary_to_bcd_converter.sv - handshaked sequential double-dabble binary-to-BCD converter
// Optional two's-complement input with sign output: define BIN2BCD_SIGNED_EN.
module binary_to_bcd_converter
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_digit_en,
  output logic                  out_neg
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [WIDTH-1:0]    r_src;
  logic [4*DIGITS-1:0] r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic [4*DIGITS-1:0] r_out_bcd;
  logic [DIGITS-1:0]   r_out_digit_en;
  logic [WIDTH-1:0]    w_load_data;
  logic [4*DIGITS-1:0] w_bcd_adj;
  logic [4*DIGITS-1:0] w_bcd_next;
  logic [DIGITS-1:0]   w_digit_en;
  logic                w_seen;
  logic                w_last_shift;
  logic                w_unused_bcd_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  // The corrected top digit never reaches 8, so the bit shifted out is always zero.
  assign w_unused_bcd_msb = w_bcd_adj[4*DIGITS-1];
  assign w_bcd_next       = {w_bcd_adj[4*DIGITS-2:0], r_src[WIDTH-1]};
  assign w_last_shift     = (r_state == SHIFT) && (r_cnt == LAST_CNT);

  always_comb begin
    w_digit_en = '0;
    w_seen     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_seen        = w_seen | (w_bcd_next[4*i +: 4] != 4'd0);
      w_digit_en[i] = w_seen;
    end
    w_digit_en[0] = 1'b1;
  end

`ifdef BIN2BCD_SIGNED_EN
  logic w_in_neg;
  logic r_sign;
  logic r_out_neg;

  assign w_in_neg    = in_data[WIDTH-1];
  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
  assign w_load_data = w_in_neg ? (-in_data) : in_data;
  assign out_neg     = r_out_neg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign    <= 1'b0;
      r_out_neg <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) r_sign <= w_in_neg;
      if (w_last_shift) r_out_neg <= r_sign;
    end
  end
`else
  assign w_load_data = in_data;
  assign out_neg     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == LAST_CNT) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src          <= '0;
      r_bcd          <= '0;
      r_cnt          <= '0;
      r_out_bcd      <= '0;
      r_out_digit_en <= DIGITS'(1);
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_src <= w_load_data;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_src <= {r_src[WIDTH-2:0], 1'b0};
          r_bcd <= w_bcd_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last_shift) begin
            r_out_bcd      <= w_bcd_next;
            r_out_digit_en <= w_digit_en;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_bcd      = r_out_bcd;
  assign out_digit_en = r_out_digit_en;

endmodule
